// File: rtl/lcd_timing_gen_if.sv
// lcd_timing_gen_if: image window position in, image memory address out.
// master = timing generator, slave = image memory / pixel mux.
interface lcd_timing_gen_if #(
  parameter int CNT_W  = 11,
  parameter int ADDR_W = 16
);
  logic [CNT_W-1:0]  img_x;
  logic [CNT_W-1:0]  img_y;
  logic              img_ack;
  logic [ADDR_W-1:0] addr;

  modport master (
    input  img_x,
    input  img_y,
    output img_ack,
    output addr
  );

  modport slave (
    output img_x,
    output img_y,
    input  img_ack,
    input  addr
  );
endinterface

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen: parametrised LCD raster timing with an image window.
// Optional colour-bar generator enabled by LCD_TEST_PATTERN_EN.
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 32,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int IMG_W    = 100,
  parameter int IMG_H    = 100,
  parameter int CNT_W    = 11,
  parameter int ADDR_W   = 16
) (
  input  logic             clk,
  input  logic             rest_n,
  lcd_timing_gen_if.master img,
  output logic             lcd_clk,
  output logic             lcd_pwm,
  output logic             lcd_hsync,
  output logic             lcd_vsync,
  output logic             lcd_de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
`ifdef LCD_TEST_PATTERN_EN
  input  logic             pat_en,
  output logic [15:0]      pat_rgb,
`endif
  output logic             line_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int H_START = H_SYNC + H_BP;
  localparam int V_START = V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] HA_BEG  = CNT_W'(H_START);
  localparam logic [CNT_W-1:0] HA_END  = CNT_W'(H_START + H_ACTIVE);
  localparam logic [CNT_W-1:0] HA_LAST = CNT_W'(H_START + H_ACTIVE - 1);
  localparam logic [CNT_W-1:0] VA_BEG  = CNT_W'(V_START);
  localparam logic [CNT_W-1:0] VA_END  = CNT_W'(V_START + V_ACTIVE);

  localparam logic [CNT_W:0]    IMG_W_E  = (CNT_W+1)'(IMG_W);
  localparam logic [CNT_W:0]    IMG_H_E  = (CNT_W+1)'(IMG_H);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

  localparam longint IMG_WORDS = longint'(IMG_W) * longint'(IMG_H);
  localparam longint ADDR_SPAN = longint'(1) << ADDR_W;

  logic [CNT_W-1:0]  h_cnt;
  logic [CNT_W-1:0]  v_cnt;
  logic [CNT_W-1:0]  sx;
  logic [CNT_W-1:0]  sy;
  logic [ADDR_W-1:0] row_base;

  logic              sof;
  logic              h_act;
  logic              v_act;
  logic              de_d;
  logic [CNT_W-1:0]  hx;
  logic [CNT_W-1:0]  vy;
  logic              row_in;
  logic              col_in;
  logic              ack_d;
  logic              eol;
  logic [ADDR_W-1:0] addr_d;

  assign lcd_clk = clk & rest_n;

  // Address space must hold the whole window image.
  a_cfg_addr: assert property (@(posedge clk) IMG_WORDS <= ADDR_SPAN);

  // Raster position counters; vertical steps on each line wrap.
  always_ff @(posedge clk) begin
    if (!rest_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end else begin
      h_cnt <= h_cnt + CNT_W'(1);
    end
  end

  // Decode the current counter position into next-cycle outputs.
  always_comb begin
    sof    = (h_cnt == '0) && (v_cnt == '0);
    h_act  = (h_cnt >= HA_BEG) && (h_cnt < HA_END);
    v_act  = (v_cnt >= VA_BEG) && (v_cnt < VA_END);
    de_d   = h_act && v_act;
    hx     = h_cnt - HA_BEG;
    vy     = v_cnt - VA_BEG;
    row_in = v_act
          && ({1'b0, vy} >= {1'b0, sy})
          && ({1'b0, vy} <  {1'b0, sy} + IMG_H_E);
    col_in = h_act
          && ({1'b0, hx} >= {1'b0, sx})
          && ({1'b0, hx} <  {1'b0, sx} + IMG_W_E);
    ack_d  = row_in && col_in;
`ifdef LCD_TEST_PATTERN_EN
    if (pat_en) ack_d = 1'b0;
`endif
    eol    = (h_cnt == HA_LAST) && row_in;
    addr_d = ack_d ? row_base + ADDR_W'(hx - sx) : '0;
  end

  // Window shadow latched once per frame; row base walks window rows.
  always_ff @(posedge clk) begin
    if (!rest_n) begin
      sx       <= '0;
      sy       <= '0;
      row_base <= '0;
    end else if (sof) begin
      sx       <= img.img_x;
      sy       <= img.img_y;
      row_base <= '0;
    end else if (eol) begin
      row_base <= row_base + ROW_STEP;
    end
  end

`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0]  bar;
  logic [15:0] rgb_d;

  // Colour bar index from the active-area x position.
  always_comb begin
    bar   = '0;
    rgb_d = '0;
    for (int k = 1; k < 8; k++)
      if (hx >= CNT_W'(k * BAR_W)) bar = 3'(k);
    unique case (bar)
      3'd0: rgb_d = 16'hFFFF;
      3'd1: rgb_d = 16'hFFE0;
      3'd2: rgb_d = 16'h07FF;
      3'd3: rgb_d = 16'h07E0;
      3'd4: rgb_d = 16'hF81F;
      3'd5: rgb_d = 16'hF800;
      3'd6: rgb_d = 16'h001F;
      3'd7: rgb_d = 16'h0000;
    endcase
    if (!(de_d && pat_en)) rgb_d = '0;
  end

  // Pattern output registered alongside lcd_de.
  always_ff @(posedge clk) begin
    if (!rest_n) pat_rgb <= '0;
    else         pat_rgb <= rgb_d;
  end
`endif

  // Registered panel and image outputs, one cycle behind the counters.
  always_ff @(posedge clk) begin
    if (!rest_n) begin
      lcd_pwm     <= 1'b0;
      lcd_hsync   <= ~HS_POL;
      lcd_vsync   <= ~VS_POL;
      lcd_de      <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      img.img_ack <= 1'b0;
      img.addr    <= '0;
    end else begin
      lcd_pwm     <= 1'b1;
      lcd_hsync   <= (h_cnt < HS_END) ? HS_POL : ~HS_POL;
      lcd_vsync   <= (v_cnt < VS_END) ? VS_POL : ~VS_POL;
      lcd_de      <= de_d;
      pix_x       <= de_d ? hx : '0;
      pix_y       <= de_d ? vy : '0;
      frame_start <= sof;
      line_start  <= (h_cnt == '0);
      img.img_ack <= ack_d;
      img.addr    <= addr_d;
    end
  end

endmodule
